instr_buffer: RTL and testbench
===============================

Name: instr_buffer

Overview:
- Parametrised instruction buffer between instruction memory and decode.
- Generalises the single-entry instruction register into a DEPTH-entry FIFO of {pc, instr} pairs, with valid/ready handshakes on both sides.
- Adds a flush input for branch/jump redirects.
- The output presents NOP (all-zero) whenever the buffer is empty or in reset.

Parameters:
- DATA_W, 32, instruction width in bits.
- PC_W, 32, width of the PC tag stored with each instruction.
- DEPTH, 4, number of entries; power of two, ≥2.
- CNT_W, $clog2(DEPTH+1), width of the occupancy count (derived, not overridable).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-low reset. Assertion clears immediately; release is synchronous to clk.
- in_valid  in  1  IM offers an instruction this cycle.
- in_pc  in  PC_W  PC of offered instruction.
- in_instr  in  DATA_W  offered instruction word.
- in_ready  out  1  buffer accepts this cycle.
- out_valid  out  1  head entry valid.
- out_pc  out  PC_W  PC of head entry.
- out_instr  out  DATA_W  instruction of head entry.
- out_ready  in  1  decode consumes head this cycle.
- flush  in  1  discard all entries.
- count  out  CNT_W  current occupancy, 0..DEPTH.

Behaviour:
- Reset (rst=0, asynchronous):
  - wr_ptr=rd_ptr=0, count=0.
  - out_valid=0, out_instr=0, out_pc=0, in_ready=1.
  - Storage contents are don't-care.
- Push = in_valid & in_ready. Pop = out_valid & out_ready.
- in_ready = (count != DEPTH). Combinational from registered state only; no dependence on out_ready.
  - When full, a simultaneous pop does not enable a push in that cycle.
- out_valid = (count != 0).
- out_pc and out_instr are the head entry when out_valid=1; forced to 0 (NOP) when out_valid=0.
- Latency: an entry pushed at edge N is visible on the outputs after edge N. There is no combinational input-to-output bypass.
- Pointers: log2(DEPTH) bits, natural wrap-around (DEPTH-1 → 0).
- count update:
  - +1 on push only.
  - -1 on pop only.
  - unchanged on simultaneous push and pop.
- Simultaneous push and pop at count=1: the head advances to the new entry. out_valid stays 1 with no bubble.
- Pop with out_valid=0 is ignored. Push with in_ready=0 is ignored; the upstream source must hold its data.
- Flush (synchronous, highest priority):
  - At the edge, pointers and count go to 0.
  - Any push or pop in the same cycle is discarded.
  - Next cycle: out_valid=0, in_ready=1.
- Reset asserted mid-operation: all state is cleared regardless of handshakes in flight.
- No X propagation: outputs are defined in all states.

Decomposition:
- Shared package, cpu_pkg:
  - constant NOP_INSTR = 32'h00000000;
  - default width constants INSTR_W=32, PC_W=32.
- One natural sub-module: instr_buffer_mem, a DEPTH×(PC_W+DATA_W) register array.
  - Ports: clk, we, waddr, wdata, raddr, rdata.
  - No reset on storage.
- Pointer, count and handshake logic stay in instr_buffer.

Test Plan:
- Reset: drive rst=0 mid-simulation with count=3 → immediately count=0, out_valid=0, out_instr=0, in_ready=1. After release, state holds until the first push.
- Fill and drain (DEPTH=4): push pc 0x00,0x04,0x08,0x0C with instr 0xA0..0xA3, out_ready=0 → count=4, in_ready=0. A fifth push is ignored. Then pop 4 → 0xA0..0xA3 in order, then out_valid=0, out_instr=0.
- Streaming: in_valid=1 and out_ready=1 every cycle for 20 cycles from empty → after a 1-cycle fill, count stays 1, output sequence equals input sequence, no bubbles.
- Wrap-around: 10 push/pop mixed cycles crossing the pointer wrap twice → FIFO order preserved and count matches a reference model each cycle.
- Flush: count=3, then flush=1 with in_valid=1 and out_ready=1 in the same cycle → next cycle count=0, out_valid=0. The pushed word never appears on the output.
- Full with pop: count=4, in_valid=1, out_ready=1 → pop only, count=3, in_ready=1 the next cycle.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU constants used by the fetch-side blocks.
package cpu_pkg;

    localparam int INSTR_W = 32;
    localparam int PC_W    = 32;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h00000000;

endpackage

// File: rtl/instr_buffer_mem.sv
// Storage array for the instruction buffer: synchronous write, combinational read, no reset.
module instr_buffer_mem #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/instr_buffer.sv
// DEPTH-entry FIFO of {pc, instr} pairs between instruction memory and decode.
// Presents a NOP with a zero PC whenever the buffer is empty.
module instr_buffer #(
    parameter int  DATA_W = cpu_pkg::INSTR_W,
    parameter int  PC_W   = cpu_pkg::PC_W,
    parameter int  DEPTH  = 4,
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [PC_W-1:0]   in_pc,
    input  logic [DATA_W-1:0] in_instr,
    output logic              in_ready,
    output logic              out_valid,
    output logic [PC_W-1:0]   out_pc,
    output logic [DATA_W-1:0] out_instr,
    input  logic              out_ready,
    input  logic              flush,
    output logic [CNT_W-1:0]  count
);

    import cpu_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam int EW = PC_W + DATA_W;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [EW-1:0] head;
    logic          push;
    logic          pop;

    instr_buffer_mem #(
        .DEPTH (DEPTH),
        .WIDTH (EW),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (push && !flush),
        .waddr (wr_ptr),
        .wdata ({in_pc, in_instr}),
        .raddr (rd_ptr),
        .rdata (head)
    );

    // Ready depends only on registered occupancy, so a pop while full cannot admit a push.
    assign in_ready  = (count != FULL);
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign out_pc    = out_valid ? head[EW-1:DATA_W] : '0;
    assign out_instr = out_valid ? head[DATA_W-1:0]  : DATA_W'(NOP_INSTR);

    // Flush wins over any handshake in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_instr_buffer.sv
// Directed self-checking bench for instr_buffer (DEPTH=4) with hand-computed expectations.
module tb_instr_buffer;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_pc;
    logic [31:0] in_instr;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        out_ready;
    logic        flush;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;

    instr_buffer #(
        .DATA_W (32),
        .PC_W   (32),
        .DEPTH  (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_pc     (in_pc),
        .in_instr  (in_instr),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_pc    (out_pc),
        .out_instr (out_instr),
        .out_ready (out_ready),
        .flush     (flush),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic apply_stimulus(input logic v, input logic [31:0] pc, input logic [31:0] instr,
                                  input logic rdy, input logic fl);
        in_valid  = v;
        in_pc     = pc;
        in_instr  = instr;
        out_ready = rdy;
        flush     = fl;
    endtask

    task automatic check_empty(input string tag);
        check({tag, " count"}, 64'(count), 64'd0);
        check({tag, " out_valid"}, 64'(out_valid), 64'd0);
        check({tag, " out_instr"}, 64'(out_instr), 64'd0);
        check({tag, " out_pc"}, 64'(out_pc), 64'd0);
        check({tag, " in_ready"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        logic [31:0] model_q[$];
        logic [9:0]  push_pat;
        logic [9:0]  pop_pat;
        logic        push_ok;
        logic        pop_ok;

        rst = 1'b0;
        apply_stimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        #1;
        check_empty("reset");
        step();
        step();
        #2 rst = 1'b1;
        step();
        check_empty("post_release");

        // Fill to capacity, then attempt an overflow push.
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(1'b1, 32'(i * 4), 32'hA0 + 32'(i), 1'b0, 1'b0);
            step();
            check("fill count", 64'(count), 64'(i + 1));
        end
        check("full in_ready", 64'(in_ready), 64'd0);
        check("full head instr", 64'(out_instr), 64'hA0);
        check("full head pc", 64'(out_pc), 64'h0);
        apply_stimulus(1'b1, 32'h10, 32'hFF, 1'b0, 1'b0);
        step();
        check("overflow count", 64'(count), 64'd4);

        apply_stimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            check("drain instr", 64'(out_instr), 64'hA0 + 64'(i));
            check("drain pc", 64'(out_pc), 64'(i * 4));
            step();
            check("drain count", 64'(count), 64'(3 - i));
        end
        check_empty("drained");

        // Streaming: one push and one pop every cycle after the first fill.
        for (int k = 0; k < 20; k++) begin
            apply_stimulus(1'b1, 32'h1000 + 32'(4 * k), 32'h100 + 32'(k), 1'b1, 1'b0);
            if (k > 0) begin
                check("stream valid", 64'(out_valid), 64'd1);
                check("stream instr", 64'(out_instr), 64'h100 + 64'(k - 1));
                check("stream pc", 64'(out_pc), 64'h1000 + 64'(4 * (k - 1)));
            end
            step();
            check("stream count", 64'(count), 64'd1);
        end
        apply_stimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        check("stream last", 64'(out_instr), 64'h113);
        step();
        check_empty("stream end");

        // Mixed push/pop pattern against a queue model; nine pushes wrap the pointers twice.
        push_pat = 10'b11_1111_0111;
        pop_pat  = 10'b11_1011_1010;
        for (int c = 0; c < 10; c++) begin
            apply_stimulus(push_pat[c], 32'h2000 + 32'(4 * c), 32'hB00 + 32'(c), pop_pat[c], 1'b0);
            check("wrap valid", 64'(out_valid), 64'(model_q.size() != 0));
            check("wrap instr", 64'(out_instr), (model_q.size() != 0) ? 64'(model_q[0]) : 64'd0);
            push_ok = push_pat[c] && (model_q.size() != 4);
            pop_ok  = pop_pat[c] && (model_q.size() != 0);
            step();
            if (pop_ok) void'(model_q.pop_front());
            if (push_ok) model_q.push_back(32'hB00 + 32'(c));
            check("wrap count", 64'(count), 64'(model_q.size()));
        end
        apply_stimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        for (int c = 0; c < 4 && model_q.size() != 0; c++) begin
            check("wrap drain instr", 64'(out_instr), 64'(model_q[0]));
            step();
            void'(model_q.pop_front());
            check("wrap drain count", 64'(count), 64'(model_q.size()));
        end
        check_empty("wrap end");

        // Flush with a push and pop in flight.
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(1'b1, 32'h3000 + 32'(4 * i), 32'hD0 + 32'(i), 1'b0, 1'b0);
            step();
        end
        check("preflush count", 64'(count), 64'd3);
        apply_stimulus(1'b1, 32'h300C, 32'hDEAD, 1'b1, 1'b1);
        step();
        apply_stimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        check_empty("flush");
        step();
        check_empty("flush hold");

        // Full with simultaneous pop: pop only.
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(1'b1, 32'h4000 + 32'(4 * i), 32'hC0 + 32'(i), 1'b0, 1'b0);
            step();
        end
        check("full2 count", 64'(count), 64'd4);
        check("full2 in_ready", 64'(in_ready), 64'd0);
        apply_stimulus(1'b1, 32'h4010, 32'hEE, 1'b1, 1'b0);
        step();
        check("fullpop count", 64'(count), 64'd3);
        check("fullpop in_ready", 64'(in_ready), 64'd1);
        apply_stimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        for (int i = 1; i < 4; i++) begin
            check("fullpop drain", 64'(out_instr), 64'hC0 + 64'(i));
            step();
        end
        check_empty("fullpop end");

        // Asynchronous reset in the middle of a cycle with handshakes pending.
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(1'b1, 32'h5000 + 32'(4 * i), 32'hE0 + 32'(i), 1'b0, 1'b0);
            step();
        end
        check("prereset count", 64'(count), 64'd3);
        apply_stimulus(1'b1, 32'h500C, 32'hE3, 1'b1, 1'b0);
        #2 rst = 1'b0;
        #1;
        check_empty("async reset");
        step();
        check_empty("reset held");
        apply_stimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        #2 rst = 1'b1;
        step();
        check_empty("reset release");
        apply_stimulus(1'b1, 32'h6000, 32'hF0, 1'b0, 1'b0);
        step();
        apply_stimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        check("after reset count", 64'(count), 64'd1);
        check("after reset instr", 64'(out_instr), 64'hF0);
        check("after reset pc", 64'(out_pc), 64'h6000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
